// File: rtl/fullsub_bist.sv
// Self-test engine for a 1-bit full subtractor: sweeps all 8 {a,b,bin} vectors PASSES times and checks d/b0.
// Latency: done rises 16*PASSES clock edges after the edge that samples start (2 cycles per vector).
// No backpressure: start is a level request honoured only in IDLE/DONE; it is ignored while busy.
module fullsub_bist #(
   parameter int PASSES = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             bin,
   input  logic             d,
   input  logic             b0,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       fail_vec,
   output logic             fail_valid
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [7:0]       LAST_PASS = 8'(PASSES - 1);

   logic [1:0] state;
   logic [2:0] v;
   logic [7:0] pass_cnt;
   logic       exp_d;
   logic       exp_b;
   logic       mismatch;

   // Golden full-subtractor response for the vector currently on the bus.
   always_comb begin
      exp_d    = v[2] ^ v[1] ^ v[0];
      exp_b    = (~v[2] & v[1]) | (~(v[2] ^ v[1]) & v[0]);
      mismatch = (d != exp_d) || (b0 != exp_b);
   end

   // Stimulus is only presented while a run is active; it is parked at zero otherwise.
   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
      pass = done && (err_count == '0);
      a    = busy & v[2];
      b    = busy & v[1];
      bin  = busy & v[0];
   end

   // Sequencer: one settle cycle (DRIVE) then one compare cycle (SAMPLE) per vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         v          <= 3'd0;
         pass_cnt   <= 8'd0;
         err_count  <= '0;
         fail_vec   <= 3'd0;
         fail_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  v          <= 3'd0;
                  pass_cnt   <= 8'd0;
                  err_count  <= '0;
                  fail_vec   <= 3'd0;
                  fail_valid <= 1'b0;
               end
            end
            DRIVE: begin
               state <= SAMPLE;
            end
            SAMPLE: begin
               if (mismatch) begin
                  if (err_count != ERR_MAX) begin
                     err_count <= err_count + 1'b1;
                  end
                  // Only the first failing vector of a run is recorded.
                  if (!fail_valid) begin
                     fail_vec   <= v;
                     fail_valid <= 1'b1;
                  end
               end
               if (v != 3'd7) begin
                  v     <= v + 3'd1;
                  state <= DRIVE;
               end else if (pass_cnt != LAST_PASS) begin
                  v        <= 3'd0;
                  pass_cnt <= pass_cnt + 8'd1;
                  state    <= DRIVE;
               end else begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fullsub_bist.md
FULLSUB_BIST -- requirements
Module: fullsub_bist

Interface
REQ-001 The block SHALL have parameter PASSES, default 1, the number of complete 8-vector sweeps per run (legal 1..255).
REQ-002 The block SHALL have parameter ERR_W, default 8, the width of the mismatch counter.
REQ-003 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  a run request, sampled only in IDLE or DONE.
REQ-006 The block SHALL have ports a, b, bin  output  1 each  the stimulus to the full subtractor under test.
REQ-007 The block SHALL have ports d, b0  input  1 each  the difference and borrow-out returned by the subtractor under test.
REQ-008 The block SHALL have port busy  output  1  high in DRIVE or SAMPLE.
REQ-009 The block SHALL have port done  output  1  high in DONE.
REQ-010 The block SHALL have port pass  output  1  high when done=1 and err_count=0.
REQ-011 The block SHALL have port err_count  output  ERR_W  the number of mismatching vectors in the current run.
REQ-012 The block SHALL have port fail_vec  output  3  the {a,b,bin} of the first mismatching vector in the run.
REQ-013 The block SHALL have port fail_valid  output  1  high once fail_vec has been captured.

Function
REQ-014 The block SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 The block SHALL hold a 3-bit vector index v and drive a=v[2], b=v[1], bin=v[0] from registers in DRIVE and SAMPLE, so that a toggles slowest and bin fastest.
REQ-016 The block SHALL drive a=b=bin=0 in IDLE and DONE.
REQ-017 On a clock edge in IDLE or DONE with start=1, the block SHALL do all of the following:
- go to DRIVE;
- set v=0 and clear the pass counter;
- clear err_count, fail_vec and fail_valid.
REQ-018 In DRIVE, the block SHALL go to SAMPLE on the next edge, giving the subtractor under test one full cycle to settle.
REQ-019 On the edge that leaves SAMPLE, the block SHALL compare d against the expected difference a^b^bin.
REQ-020 On the same edge, the block SHALL compare b0 against the expected borrow (~a&b)|(~(a^b)&bin).
REQ-021 A vector SHALL count as one mismatch if either bit differs.
REQ-022 On a mismatch, err_count SHALL increment by 1 and SHALL saturate at 2^ERR_W-1 without wrapping.
REQ-023 On the first mismatch of a run, the block SHALL capture {a,b,bin} into fail_vec and set fail_valid=1; later mismatches SHALL NOT change fail_vec.
REQ-024 When leaving SAMPLE with v<7, the block SHALL set v=v+1 and go to DRIVE.
REQ-025 When leaving SAMPLE with v=7 and fewer than PASSES sweeps done, the block SHALL wrap v to 0, increment the pass counter and go to DRIVE.
REQ-026 When leaving SAMPLE with v=7 on the last sweep, the block SHALL go to DONE.
REQ-027 Latency: when start is sampled at edge k, done SHALL first be high after edge k+16*PASSES.
REQ-028 busy SHALL be high from edge k+1 up to that point.
REQ-029 The block SHALL ignore start while busy=1.
REQ-030 In DONE, the block SHALL hold err_count, fail_vec, fail_valid and pass stable until a new start or a reset.

Reset
REQ-031 While rst=1, the block SHALL immediately, without waiting for clk, do all of the following:
- go to IDLE;
- set v=0 and the pass counter to 0;
- drive a=b=bin=0, busy=0, done=0, pass=0;
- set err_count=0, fail_vec=0, fail_valid=0.
REQ-032 A reset in DRIVE or SAMPLE SHALL abort the run with no partial result kept.
REQ-033 After reset the block SHALL need a new start to run.

Verification
REQ-034 Correct full-subtractor model, PASSES=1, start pulsed for one cycle -> done high after 16 edges, err_count=0, pass=1, fail_valid=0; the a/b/bin sequence is 000,001,...,111, each held for 2 cycles.
REQ-035 Model with b0 stuck at 0 -> err_count=4 (vectors 001,010,011,111), fail_vec=3'b001, fail_valid=1, pass=0.
REQ-036 Model with d inverted, PASSES=3 -> err_count=24, fail_vec=3'b000, done after 48 edges; with ERR_W=2 instead -> err_count saturates at 3.
REQ-037 rst asserted mid-run while v=5 in SAMPLE -> all outputs 0 without waiting for clk; a following start gives a clean full run with the correct result.
REQ-038 start held high for the whole run -> a single run of 16 edges, then an immediate restart from DONE with the counters cleared.
